// File: rtl/mcpu_writeback_sequencer.sv
// Register-file writeback sequencer: buffers execute-stage writeback commands in a
// small FIFO and replays each one as a setup / rising-edge / hold strobe on regsetwb.
module mcpu_writeback_sequencer #(
  parameter int WORD_SIZE       = 8,
  parameter int OPERAND_SIZE    = 12,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic [1:0]              ex_cmd,
  input  logic [OPERAND_SIZE-1:0] ex_op1,
  input  logic [OPERAND_SIZE-1:0] ex_op2,
  input  logic [WORD_SIZE-1:0]    ex_data,
  output logic [OPERAND_SIZE-1:0] op1,
  output logic [OPERAND_SIZE-1:0] op2,
  output logic [WORD_SIZE-1:0]    datatoload,
  output logic [1:0]              regsetcmd,
  output logic                    regsetwb,
  output logic                    pending,
  output logic [15:0]             wb_count
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int ENTRY_W = 2 + 2 * OPERAND_SIZE + WORD_SIZE;
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);
  localparam logic [1:0]                 CMD_NOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t                     state_r;
  logic [ENTRY_W-1:0]         mem_r [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_r;
  logic [FIFO_DEPTH_LOG2:0]   count_r;

  logic                    full_s;
  logic                    empty_s;
  logic                    push_s;
  logic                    pop_s;
  logic [ENTRY_W-1:0]      head_s;
  logic [1:0]              head_cmd_s;
  logic [OPERAND_SIZE-1:0] head_op1_s;
  logic [OPERAND_SIZE-1:0] head_op2_s;
  logic [WORD_SIZE-1:0]    head_data_s;

  assign full_s   = (count_r == CNT_FULL);
  assign empty_s  = (count_r == '0);
  assign push_s   = ex_valid && !full_s;
  // The head is only consumed between strobes, never while a write is in flight.
  assign pop_s    = ((state_r == IDLE) || (state_r == HOLD)) && !empty_s;
  assign ex_ready = !full_s;
  assign pending  = !empty_s || (state_r != IDLE);

  assign head_s = mem_r[rd_ptr_r];
  assign {head_cmd_s, head_op1_s, head_op2_s, head_data_s} = head_s;

  // FIFO storage; entries are dead data until the pointers make them visible.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {ex_cmd, ex_op1, ex_op2, ex_data};
    end
  end

  // FIFO pointers, strobe sequencer and registered register-file interface.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      state_r    <= IDLE;
      regsetwb   <= 1'b0;
      regsetcmd  <= CMD_NOP;
      op1        <= '0;
      op2        <= '0;
      datatoload <= '0;
      wb_count   <= 16'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase

      case (state_r)
        IDLE, HOLD: begin
          regsetwb <= 1'b0;
          if (pop_s && (head_cmd_s != CMD_NOP)) begin
            op1        <= head_op1_s;
            op2        <= head_op2_s;
            datatoload <= head_data_s;
            regsetcmd  <= head_cmd_s;
            state_r    <= SETUP;
          end else begin
            // A popped DO_NOTHING and an empty queue both park the interface idle.
            regsetcmd <= CMD_NOP;
            state_r   <= IDLE;
          end
        end
        SETUP: begin
          regsetwb <= 1'b1;
          wb_count <= wb_count + 16'd1;
          state_r  <= STROBE;
        end
        STROBE: begin
          regsetwb <= 1'b0;
          state_r  <= HOLD;
        end
        default: begin
          regsetwb <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_writeback_sequencer.sv
// Directed bench for mcpu_writeback_sequencer with a small register-file model
// attached to the strobe outputs.
module tb_mcpu_writeback_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_cmd;
  logic [11:0] ex_op1;
  logic [11:0] ex_op2;
  logic [7:0]  ex_data;
  logic [11:0] op1;
  logic [11:0] op2;
  logic [7:0]  datatoload;
  logic [1:0]  regsetcmd;
  logic        regsetwb;
  logic        pending;
  logic [15:0] wb_count;

  int errors = 0;
  int checks = 0;

  // Register-file model and strobe log, both driven only by regsetwb rising.
  logic [7:0]  rf [16];
  logic [11:0] strobe_op1 [64];
  int          strobe_cnt = 0;

  mcpu_writeback_sequencer #(
    .WORD_SIZE(8),
    .OPERAND_SIZE(12),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .ex_cmd(ex_cmd),
    .ex_op1(ex_op1),
    .ex_op2(ex_op2),
    .ex_data(ex_data),
    .op1(op1),
    .op2(op2),
    .datatoload(datatoload),
    .regsetcmd(regsetcmd),
    .regsetwb(regsetwb),
    .pending(pending),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  always @(posedge regsetwb) begin
    case (regsetcmd)
      2'd0, 2'd2: rf[op1[3:0]] <= datatoload;
      2'd1:       rf[op1[3:0]] <= rf[op2[3:0]];
      default:    ;
    endcase
    strobe_op1[strobe_cnt[5:0]] <= op1;
    strobe_cnt <= strobe_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    ex_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive(input logic [1:0] c, input logic [11:0] a, input logic [11:0] b,
                       input logic [7:0] d);
    ex_valid = 1'b1;
    ex_cmd   = c;
    ex_op1   = a;
    ex_op2   = b;
    ex_data  = d;
  endtask

  initial begin
    int idx;
    int s0;
    int acc_edge [7];
    logic rdy;

    ex_cmd  = 2'd0;
    ex_op1  = 12'd0;
    ex_op2  = 12'd0;
    ex_data = 8'd0;

    // Reset state, observed right after the second reset edge.
    reset    = 1'b1;
    ex_valid = 1'b0;
    tick();
    tick();
    chk("rst_regsetwb", 32'(regsetwb), 32'd0);
    chk("rst_regsetcmd", 32'(regsetcmd), 32'd3);
    chk("rst_op1", 32'(op1), 32'd0);
    chk("rst_op2", 32'(op2), 32'd0);
    chk("rst_data", 32'(datatoload), 32'd0);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_wb_count", 32'(wb_count), 32'd0);
    reset = 1'b0;

    // Single NORMAL_EX op1=5 data=A5 accepted at edge 0.
    s0 = strobe_cnt;
    drive(2'd0, 12'd5, 12'd0, 8'hA5);
    tick();
    ex_valid = 1'b0;
    chk("one_e0_pending", 32'(pending), 32'd1);
    chk("one_e0_wb", 32'(regsetwb), 32'd0);
    tick();
    chk("one_e1_op1", 32'(op1), 32'd5);
    chk("one_e1_cmd", 32'(regsetcmd), 32'd0);
    chk("one_e1_data", 32'(datatoload), 32'hA5);
    chk("one_e1_wb", 32'(regsetwb), 32'd0);
    tick();
    chk("one_e2_wb", 32'(regsetwb), 32'd1);
    chk("one_e2_count", 32'(wb_count), 32'd1);
    tick();
    chk("one_e3_wb", 32'(regsetwb), 32'd0);
    chk("one_e3_op1", 32'(op1), 32'd5);
    chk("one_e3_cmd", 32'(regsetcmd), 32'd0);
    tick();
    chk("one_e4_cmd", 32'(regsetcmd), 32'd3);
    chk("one_e4_pending", 32'(pending), 32'd0);
    chk("one_e4_count", 32'(wb_count), 32'd1);
    chk("one_e4_op1_held", 32'(op1), 32'd5);
    chk("one_rf5", 32'(rf[5]), 32'hA5);
    chk("one_strobes", 32'(strobe_cnt - s0), 32'd1);

    // Seven back-to-back NORMAL_EX commands; command k writes R[k+1]=0x11+k.
    reset_dut();
    s0  = strobe_cnt;
    idx = 0;
    drive(2'd0, 12'd1, 12'd0, 8'h11);
    for (int e = 0; e <= 22; e++) begin
      rdy = ex_ready;
      tick();
      if (ex_valid && rdy) begin
        acc_edge[idx] = e;
        idx++;
        if (idx < 7) begin
          ex_op1  = 12'(idx + 1);
          ex_data = 8'(8'h11 + idx);
        end else begin
          ex_valid = 1'b0;
        end
      end
      chk($sformatf("seq_wb_e%0d", e), 32'(regsetwb), (e % 3 == 2) ? 32'd1 : 32'd0);
      if (e <= 7) begin
        chk($sformatf("seq_ready_e%0d", e), 32'(ex_ready), (e == 5 || e == 6) ? 32'd0 : 32'd1);
      end
    end
    chk("seq_accepted", 32'(idx), 32'd7);
    chk("seq_7th_edge", 32'(acc_edge[6]), 32'd8);
    chk("seq_count", 32'(wb_count), 32'd7);
    chk("seq_strobes", 32'(strobe_cnt - s0), 32'd7);
    chk("seq_pending", 32'(pending), 32'd0);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("seq_order%0d", k), 32'(strobe_op1[(s0 + k) % 64]), 32'(k + 1));
      chk($sformatf("seq_rf%0d", k + 1), 32'(rf[k + 1]), 32'(8'h11 + k));
    end

    // R[7]=0x3C, then MOV_INTERNAL R[2] <- R[7].
    reset_dut();
    s0 = strobe_cnt;
    drive(2'd0, 12'd7, 12'd0, 8'h3C);
    tick();
    drive(2'd1, 12'd2, 12'd7, 8'h00);
    tick();
    ex_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mov_e4_op1", 32'(op1), 32'd2);
    chk("mov_e4_op2", 32'(op2), 32'd7);
    chk("mov_e4_cmd", 32'(regsetcmd), 32'd1);
    chk("mov_e4_wb", 32'(regsetwb), 32'd0);
    tick();
    chk("mov_e5_wb", 32'(regsetwb), 32'd1);
    chk("mov_e5_op2", 32'(op2), 32'd7);
    chk("mov_e5_cmd", 32'(regsetcmd), 32'd1);
    tick();
    chk("mov_e6_wb", 32'(regsetwb), 32'd0);
    chk("mov_e6_op2", 32'(op2), 32'd7);
    chk("mov_e6_cmd", 32'(regsetcmd), 32'd1);
    tick();
    chk("mov_e7_cmd", 32'(regsetcmd), 32'd3);
    chk("mov_e7_pending", 32'(pending), 32'd0);
    chk("mov_count", 32'(wb_count), 32'd2);
    chk("mov_strobes", 32'(strobe_cnt - s0), 32'd2);
    chk("mov_rf2", 32'(rf[2]), 32'h3C);

    // A (NORMAL_EX), DO_NOTHING, B (LOAD_FROM_DATA with high operand bits set).
    reset_dut();
    s0 = strobe_cnt;
    drive(2'd0, 12'd3, 12'd0, 8'h5A);
    tick();
    drive(2'd3, 12'd9, 12'd9, 8'hFF);
    tick();
    drive(2'd2, 12'hAB4, 12'd0, 8'h22);
    tick();
    ex_valid = 1'b0;
    chk("skip_e2_wb", 32'(regsetwb), 32'd1);
    tick();
    chk("skip_e3_wb", 32'(regsetwb), 32'd0);
    tick();
    chk("skip_e4_wb", 32'(regsetwb), 32'd0);
    chk("skip_e4_cmd", 32'(regsetcmd), 32'd3);
    chk("skip_e4_op1", 32'(op1), 32'd3);
    chk("skip_e4_pending", 32'(pending), 32'd1);
    chk("skip_e4_count", 32'(wb_count), 32'd1);
    tick();
    chk("skip_e5_op1", 32'(op1), 32'hAB4);
    chk("skip_e5_cmd", 32'(regsetcmd), 32'd2);
    chk("skip_e5_data", 32'(datatoload), 32'h22);
    chk("skip_e5_wb", 32'(regsetwb), 32'd0);
    tick();
    chk("skip_e6_wb", 32'(regsetwb), 32'd1);
    tick();
    chk("skip_e7_wb", 32'(regsetwb), 32'd0);
    tick();
    chk("skip_e8_pending", 32'(pending), 32'd0);
    chk("skip_count", 32'(wb_count), 32'd2);
    chk("skip_strobes", 32'(strobe_cnt - s0), 32'd2);
    chk("skip_rf3", 32'(rf[3]), 32'h5A);
    chk("skip_rf4", 32'(rf[4]), 32'h22);

    // Reset while the first of three queued commands is strobing.
    reset_dut();
    drive(2'd0, 12'd10, 12'd0, 8'h01);
    tick();
    drive(2'd0, 12'd11, 12'd0, 8'h02);
    tick();
    drive(2'd0, 12'd12, 12'd0, 8'h03);
    tick();
    ex_valid = 1'b0;
    chk("rmid_e2_wb", 32'(regsetwb), 32'd1);
    s0    = strobe_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_wb", 32'(regsetwb), 32'd0);
    chk("rmid_count", 32'(wb_count), 32'd0);
    chk("rmid_pending", 32'(pending), 32'd0);
    chk("rmid_ready", 32'(ex_ready), 32'd1);
    chk("rmid_cmd", 32'(regsetcmd), 32'd3);
    for (int e = 0; e < 6; e++) begin
      tick();
      chk($sformatf("rmid_quiet%0d", e), 32'(regsetwb), 32'd0);
    end
    chk("rmid_strobes", 32'(strobe_cnt - s0), 32'd0);
    chk("rmid_count_after", 32'(wb_count), 32'd0);
    chk("rmid_pending_after", 32'(pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
